// File: rtl/word_sel_sequencer.sv
// One-hot word-select sequencer for the ChaCha20 state/key register file (direct and sequence modes).
// Optional integrity checker enabled by defining WORD_SEL_ONEHOT_CHK_EN.
module word_sel_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 dir_vld,
    input  logic [ADDR_W-1:0]    dir_addr,
    input  logic                 seq_start,
    input  logic                 seq_rdy,
    output logic [NUM_WORDS-1:0] sel,
    output logic                 sel_vld,
    output logic [ADDR_W-1:0]    sel_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 addr_err,
    output logic                 onehot_err
);

    localparam logic [ADDR_W:0]      LP_NW   = (ADDR_W+1)'(NUM_WORDS);
    localparam logic [ADDR_W-1:0]    LP_LAST = ADDR_W'(NUM_WORDS-1);
    localparam logic [NUM_WORDS-1:0] LP_ONE  = NUM_WORDS'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                 r_state, w_state_nx;
    logic [NUM_WORDS-1:0]   r_sel, w_sel_nx;
    logic                   r_sel_vld, w_vld_nx;
    logic [ADDR_W-1:0]      r_sel_idx, w_idx_nx;
    logic                   r_done, w_done_nx;
    logic                   r_addr_err, w_err_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_sel_vld  <= 1'b0;
            r_sel_idx  <= '0;
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_sel      <= w_sel_nx;
            r_sel_vld  <= w_vld_nx;
            r_sel_idx  <= w_idx_nx;
            r_done     <= w_done_nx;
            r_addr_err <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = '0;
        w_vld_nx   = 1'b0;
        w_idx_nx   = '0;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // mode arbitrates; the request belonging to the other mode is dropped
                if (!mode) begin
                    if (dir_vld) begin
                        if ({1'b0, dir_addr} < LP_NW) begin
                            w_sel_nx = LP_ONE << dir_addr;
                            w_vld_nx = 1'b1;
                            w_idx_nx = dir_addr;
                        end else begin
                            w_err_nx = 1'b1;
                        end
                    end
                end else if (seq_start) begin
                    w_state_nx = S_RUN;
                    w_sel_nx   = LP_ONE;
                    w_vld_nx   = 1'b1;
                end
            end
            S_RUN: begin
                if (!seq_rdy) begin
                    w_sel_nx = r_sel;
                    w_vld_nx = r_sel_vld;
                    w_idx_nx = r_sel_idx;
                end else if (r_sel_idx == LP_LAST) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_sel_nx = r_sel << 1;
                    w_vld_nx = 1'b1;
                    w_idx_nx = r_sel_idx + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign sel      = r_sel;
    assign sel_vld  = r_sel_vld;
    assign sel_idx  = r_sel_idx;
    assign busy     = (r_state == S_RUN);
    assign done     = r_done;
    assign addr_err = r_addr_err;

`ifdef WORD_SEL_ONEHOT_CHK_EN
    logic w_chk_bad;
    logic r_onehot_err;

    // x & (x-1) is non-zero exactly when more than one bit is set
    assign w_chk_bad = ((r_sel & (r_sel - LP_ONE)) != '0) ||
                       (r_sel_vld && (r_sel != (LP_ONE << r_sel_idx)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_onehot_err <= 1'b0;
        else        r_onehot_err <= r_onehot_err | w_chk_bad;
    end

    assign onehot_err = r_onehot_err;
`else
    assign onehot_err = 1'b0;
`endif

endmodule
